// File: rtl/lb_pkg.sv
// Shared types and defaults for the K-row sliding-window line buffer.
package lb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2
  } lb_state_e;

  localparam int LB_LINE_W = 1280;
  localparam int LB_N_ROWS = 720;
  localparam int LB_ADDR_W = 10;

  // Rows above/below the centre row in a K-line window.
  function automatic int halfk(input int k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/line_window_shift.sv
// K-slot line store: slot 0 is the top line, shifting moves slot j+1 into j
// and loads either the fetched line or an all-zero padding line into slot K-1.
module line_window_shift #(
  parameter int LINE_W = 8,
  parameter int K      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic                  load_zero,
  input  logic [LINE_W-1:0]     load_data,
  output logic [K*LINE_W-1:0]   slots
);

  logic [K*LINE_W-1:0] slots_r;
  logic [LINE_W-1:0]   line_s;

  // Select the line entering the bottom slot.
  always_comb begin
    line_s = '0;
    if (load_zero) begin
      line_s = '0;
    end else begin
      line_s = load_data;
    end
  end

  // Slot storage with clear taking priority over shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_r <= '0;
    end else if (clr) begin
      slots_r <= '0;
    end else if (shift_en) begin
      slots_r <= {line_s, slots_r[K*LINE_W-1:LINE_W]};
    end else begin
      slots_r <= slots_r;
    end
  end

  assign slots = slots_r;

endmodule

// File: rtl/window_line_buffer.sv
// Fetches one line per handshake and emits a zero-padded K-line window
// centred on each output row, with ready/valid backpressure downstream.
module window_line_buffer
  import lb_pkg::*;
#(
  parameter int LINE_W = LB_LINE_W,
  parameter int N_ROWS = LB_N_ROWS,
  parameter int ADDR_W = LB_ADDR_W,
  parameter int K      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  fetch_req,
  output logic [ADDR_W-1:0]     fetch_addr,
  input  logic                  fetch_ack,
  input  logic [LINE_W-1:0]     fetch_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [K*LINE_W-1:0]   win_data,
  output logic [ADDR_W-1:0]     win_row,
  output logic                  frame_done
);

  localparam int H = halfk(K);
  // Row arithmetic is one bit wider so r+H never wraps near the frame end.
  localparam logic [ADDR_W:0]   H_W      = (ADDR_W+1)'(H);
  localparam logic [ADDR_W:0]   N_W      = (ADDR_W+1)'(N_ROWS);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_ROWS - 1);

  lb_state_e         state_r, state_s;
  logic [ADDR_W:0]   next_fetch_r, next_fetch_s;
  logic [ADDR_W-1:0] row_r, row_s, row_inc_s;
  logic              clr_s, shift_s, load_zero_s, done_s;

  logic              busy_r, busy_s;
  logic              fetch_req_r, fetch_req_s;
  logic [ADDR_W-1:0] fetch_addr_r, fetch_addr_s;
  logic              win_valid_r, win_valid_s;
  logic [ADDR_W-1:0] win_row_r, win_row_s;
  logic              frame_done_r;

  line_window_shift #(
    .LINE_W (LINE_W),
    .K      (K)
  ) u_slots (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_s),
    .shift_en  (shift_s),
    .load_zero (load_zero_s),
    .load_data (fetch_data),
    .slots     (win_data)
  );

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      next_fetch_r <= '0;
      row_r        <= '0;
    end else begin
      state_r      <= state_s;
      next_fetch_r <= next_fetch_s;
      row_r        <= row_s;
    end
  end

  // Next-state, counter and slot-control decisions.
  always_comb begin
    state_s      = state_r;
    next_fetch_s = next_fetch_r;
    row_s        = row_r;
    row_inc_s    = row_r + ADDR_W'(1);
    clr_s        = 1'b0;
    shift_s      = 1'b0;
    load_zero_s  = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        // busy_r still high here means this is the frame_done cycle.
        if (start && !busy_r) begin
          clr_s        = 1'b1;
          next_fetch_s = '0;
          row_s        = '0;
          state_s      = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (fetch_ack) begin
          shift_s      = 1'b1;
          next_fetch_s = next_fetch_r + (ADDR_W+1)'(1);
          if (next_fetch_r < ({1'b0, row_r} + H_W)) begin
            state_s = FETCH;
          end else begin
            state_s = EMIT;
          end
        end else begin
          state_s = FETCH;
        end
      end
      EMIT: begin
        if (win_ready) begin
          if (row_r == LAST_ROW) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            row_s = row_inc_s;
            if (({1'b0, row_inc_s} + H_W) < N_W) begin
              state_s = FETCH;
            end else begin
              shift_s     = 1'b1;
              load_zero_s = 1'b1;
              state_s     = EMIT;
            end
          end
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    busy_s       = (state_s != IDLE) || done_s;
    fetch_req_s  = (state_s == FETCH);
    fetch_addr_s = next_fetch_s[ADDR_W-1:0];
    win_valid_s  = (state_s == EMIT);
    win_row_s    = row_s;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      fetch_req_r  <= 1'b0;
      fetch_addr_r <= '0;
      win_valid_r  <= 1'b0;
      win_row_r    <= '0;
      frame_done_r <= 1'b0;
    end else begin
      busy_r       <= busy_s;
      fetch_req_r  <= fetch_req_s;
      fetch_addr_r <= fetch_addr_s;
      win_valid_r  <= win_valid_s;
      win_row_r    <= win_row_s;
      frame_done_r <= done_s;
    end
  end

  assign busy       = busy_r;
  assign fetch_req  = fetch_req_r;
  assign fetch_addr = fetch_addr_r;
  assign win_valid  = win_valid_r;
  assign win_row    = win_row_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed bench for window_line_buffer: K=3/N_ROWS=4 and K=5/N_ROWS=5, LINE_W=8.
module tb_window_line_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // K=3 instance
  logic        start3, ack3, ready3, busy3, req3, valid3, done3;
  logic [7:0]  data3;
  logic [3:0]  addr3, row3;
  logic [23:0] wd3;

  // K=5 instance
  logic        start5, ack5, ready5, busy5, req5, valid5, done5;
  logic [7:0]  data5;
  logic [3:0]  addr5, row5;
  logic [39:0] wd5;

  window_line_buffer #(.LINE_W(8), .N_ROWS(4), .ADDR_W(4), .K(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .fetch_req(req3),
    .fetch_addr(addr3), .fetch_ack(ack3), .fetch_data(data3), .win_valid(valid3),
    .win_ready(ready3), .win_data(wd3), .win_row(row3), .frame_done(done3));

  window_line_buffer #(.LINE_W(8), .N_ROWS(5), .ADDR_W(4), .K(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .busy(busy5), .fetch_req(req5),
    .fetch_addr(addr5), .fetch_ack(ack5), .fetch_data(data5), .win_valid(valid5),
    .win_ready(ready5), .win_data(wd5), .win_row(row5), .frame_done(done5));

  logic [23:0] exp3 [4] = '{24'h221100, 24'h332211, 24'h443322, 24'h004433};
  logic [39:0] exp5 [5] = '{40'h3322110000, 40'h4433221100, 40'h5544332211,
                            40'h0055443322, 40'h0000554433};

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  // Memory model for dut3: ack after delay3 waiting cycles; spur3 forces an idle ack.
  int         delay3 = 0, wait3 = 0, fetch_err3 = 0, n_fetch3 = 0;
  logic       spur3 = 1'b0, hold_chk3 = 1'b1, prev_req3 = 1'b0;
  logic [3:0] prev_addr3 = 4'd0;
  logic [3:0] faddr3 [64];
  always @(posedge clk) begin
    #1;
    if (hold_chk3 && prev_req3 && !ack3 && (!req3 || addr3 !== prev_addr3)) fetch_err3++;
    prev_req3  = req3;
    prev_addr3 = addr3;
    if (req3) begin
      if (wait3 >= delay3) begin
        ack3  = 1'b1;
        data3 = 8'(8'h11 * (int'(addr3) + 1));
        faddr3[n_fetch3 % 64] = addr3;
        n_fetch3++;
        wait3 = 0;
      end else begin
        ack3 = 1'b0;
        wait3++;
      end
    end else begin
      ack3  = spur3;
      data3 = 8'hEE;
      wait3 = 0;
    end
  end

  // Memory model for dut5: zero-wait ack.
  int n_fetch5 = 0;
  always @(posedge clk) begin
    #1;
    ack5  = req5;
    data5 = 8'(8'h11 * (int'(addr5) + 1));
    if (req5) n_fetch5++;
  end

  // Window / done / overlap monitors, sampled on the falling edge.
  logic [23:0] wlog3 [64];
  logic [3:0]  rlog3 [64];
  int          acyc3 [64];
  int          n_win3 = 0, n_done3 = 0, done_cyc3 = 0, ovl3 = 0;
  logic [39:0] wlog5 [64];
  int          acyc5 [64];
  int          n_win5 = 0, n_done5 = 0, ovl5 = 0;
  always @(negedge clk) begin
    if (valid3 && ready3) begin
      wlog3[n_win3 % 64] = wd3;
      rlog3[n_win3 % 64] = row3;
      acyc3[n_win3 % 64] = cyc;
      n_win3++;
    end
    if (done3) begin
      n_done3++;
      done_cyc3 = cyc;
    end
    if (req3 && valid3) ovl3++;
    if (valid5 && ready5) begin
      wlog5[n_win5 % 64] = wd5;
      acyc5[n_win5 % 64] = cyc;
      n_win5++;
    end
    if (done5) n_done5++;
    if (req5 && valid5) ovl5++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done3(output bit seen);
    int n;
    n = 0;
    while (!done3 && n < 600) begin
      tick();
      n++;
    end
    seen = done3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start3 = 1'b0; ready3 = 1'b1; start5 = 1'b0; ready5 = 1'b1;
    repeat (3) tick();
    total++;
    if ((busy3 | req3 | valid3 | done3) !== 1'b0 || addr3 !== 4'd0 || wd3 !== 24'd0 || row3 !== 4'd0) begin
      $display("FAIL reset3: busy=%b req=%b addr=%0d valid=%b data=%h row=%0d done=%b, required all 0", busy3, req3, addr3, valid3, wd3, row3, done3);
    end else pass_cnt++;
    total++;
    if ((busy5 | req5 | valid5 | done5) !== 1'b0 || addr5 !== 4'd0 || wd5 !== 40'd0 || row5 !== 4'd0) begin
      $display("FAIL reset5: busy=%b req=%b valid=%b data=%h, required all 0", busy5, req5, valid5, wd5);
    end else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_check_frame3(input string tag);
    int bw, bf;
    bit seen;
    bw = n_win3; bf = n_fetch3;
    start3 = 1'b1; tick(); start3 = 1'b0;
    total++;
    if (busy3 !== 1'b1 || req3 !== 1'b1 || addr3 !== 4'd0) begin
      $display("FAIL %s_start: busy=%b req=%b addr=%0d, required 1 1 0", tag, busy3, req3, addr3);
    end else pass_cnt++;
    wait_done3(seen);
    total++;
    if (!seen) $display("FAIL %s_timeout: frame_done=0, required 1", tag);
    else pass_cnt++;
    total++;
    if (busy3 !== 1'b1) $display("FAIL %s_busy_done: busy=%b, required 1", tag, busy3);
    else pass_cnt++;
    tick();
    total++;
    if (busy3 !== 1'b0) $display("FAIL %s_busy_after: busy=%b, required 0", tag, busy3);
    else pass_cnt++;
    total++;
    if (n_win3 - bw !== 4) $display("FAIL %s_win_count: got %0d, required 4", tag, n_win3 - bw);
    else pass_cnt++;
    for (int r = 0; r < 4; r++) begin
      total++;
      if (wlog3[(bw + r) % 64] !== exp3[r] || rlog3[(bw + r) % 64] !== 4'(r)) begin
        $display("FAIL %s_win%0d: data=%h row=%0d, required %h row %0d", tag, r, wlog3[(bw + r) % 64], rlog3[(bw + r) % 64], exp3[r], r);
      end else pass_cnt++;
    end
    total++;
    if (n_fetch3 - bf !== 4) $display("FAIL %s_fetch_count: got %0d, required 4", tag, n_fetch3 - bf);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (faddr3[(bf + i) % 64] !== 4'(i)) $display("FAIL %s_fetch_addr%0d: got %0d, required %0d", tag, i, faddr3[(bf + i) % 64], i);
      else pass_cnt++;
    end
    total++;
    if (done_cyc3 - acyc3[(bw + 3) % 64] !== 1) $display("FAIL %s_done_lat: got %0d cycles, required 1", tag, done_cyc3 - acyc3[(bw + 3) % 64]);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    delay3 = 0;
    run_check_frame3("basic");
    total++;
    if (ovl3 !== 0) $display("FAIL basic_overlap: req&valid cycles=%0d, required 0", ovl3);
    else pass_cnt++;
  endtask

  task automatic test_delayed_ack();
    delay3 = 5;
    run_check_frame3("delay");
    total++;
    if (fetch_err3 !== 0) $display("FAIL delay_req_stable: unstable waits=%0d, required 0", fetch_err3);
    else pass_cnt++;
    delay3 = 0;
  endtask

  task automatic test_stall();
    int n, bad;
    bit seen;
    delay3 = 0; ready3 = 1'b0;
    start3 = 1'b1; tick(); start3 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (!valid3 && n < 100) begin tick(); n++; end
      total++;
      if (valid3 !== 1'b1 || row3 !== 4'(r) || wd3 !== exp3[r]) begin
        $display("FAIL stall_win%0d: valid=%b row=%0d data=%h, required 1 %0d %h", r, valid3, row3, wd3, r, exp3[r]);
      end else pass_cnt++;
      if (r == 1) begin
        bad = 0;
        repeat (4) begin
          tick();
          if (valid3 !== 1'b1 || req3 !== 1'b0 || wd3 !== 24'h332211 || row3 !== 4'd1) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL stall_hold: %0d unstable cycles, required 0", bad);
        else pass_cnt++;
      end
      ready3 = 1'b1; tick(); ready3 = 1'b0;
      if (r == 1) begin
        total++;
        if (req3 !== 1'b1 || addr3 !== 4'd3) $display("FAIL stall_next_fetch: req=%b addr=%0d, required 1 3", req3, addr3);
        else pass_cnt++;
      end
    end
    ready3 = 1'b1;
    wait_done3(seen);
    total++;
    if (!seen) $display("FAIL stall_timeout: frame_done=0, required 1");
    else pass_cnt++;
    tick();
  endtask

  task automatic test_k5();
    int bw, bf, n;
    bw = n_win5; bf = n_fetch5;
    start5 = 1'b1; tick(); start5 = 1'b0;
    n = 0;
    while (!done5 && n < 600) begin tick(); n++; end
    total++;
    if (done5 !== 1'b1) $display("FAIL k5_timeout: frame_done=0, required 1");
    else pass_cnt++;
    tick();
    total++;
    if (n_win5 - bw !== 5) $display("FAIL k5_win_count: got %0d, required 5", n_win5 - bw);
    else pass_cnt++;
    for (int r = 0; r < 5; r++) begin
      total++;
      if (wlog5[(bw + r) % 64] !== exp5[r]) $display("FAIL k5_win%0d: got %h, required %h", r, wlog5[(bw + r) % 64], exp5[r]);
      else pass_cnt++;
    end
    total++;
    if (acyc5[(bw + 3) % 64] - acyc5[(bw + 2) % 64] !== 1 || acyc5[(bw + 4) % 64] - acyc5[(bw + 3) % 64] !== 1) begin
      $display("FAIL k5_back_to_back: gaps %0d %0d, required 1 1", acyc5[(bw + 3) % 64] - acyc5[(bw + 2) % 64], acyc5[(bw + 4) % 64] - acyc5[(bw + 3) % 64]);
    end else pass_cnt++;
    total++;
    if (n_fetch5 - bf !== 5 || ovl5 !== 0) $display("FAIL k5_fetches: got %0d overlap %0d, required 5 0", n_fetch5 - bf, ovl5);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int n, bw;
    bit seen;
    delay3 = 20;
    start3 = 1'b1; tick(); start3 = 1'b0;
    n = 0;
    while (!(req3 && addr3 == 4'd2) && n < 300) begin tick(); n++; end
    total++;
    if (req3 !== 1'b1 || addr3 !== 4'd2) $display("FAIL rst_reach_addr2: req=%b addr=%0d, required 1 2", req3, addr3);
    else pass_cnt++;
    hold_chk3 = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ((busy3 | req3 | valid3 | done3) !== 1'b0 || addr3 !== 4'd0 || wd3 !== 24'd0 || row3 !== 4'd0) begin
      $display("FAIL rst_mid: busy=%b req=%b addr=%0d valid=%b data=%h row=%0d, required all 0", busy3, req3, addr3, valid3, wd3, row3);
    end else pass_cnt++;
    delay3 = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    hold_chk3 = 1'b1;
    bw = n_win3;
    start3 = 1'b1; tick(); start3 = 1'b0;
    total++;
    if (req3 !== 1'b1 || addr3 !== 4'd0) $display("FAIL rst_restart: req=%b addr=%0d, required 1 0", req3, addr3);
    else pass_cnt++;
    wait_done3(seen);
    tick();
    total++;
    if (!seen || wlog3[bw % 64] !== 24'h221100 || n_win3 - bw !== 4) begin
      $display("FAIL rst_r0: done=%b r0=%h windows=%0d, required 1 221100 4", seen, wlog3[bw % 64], n_win3 - bw);
    end else pass_cnt++;
  endtask

  task automatic test_ignored();
    logic [23:0] held;
    int bw, bd, bf;
    bit seen;
    held = wd3; bf = n_fetch3;
    spur3 = 1'b1; tick(); spur3 = 1'b0; tick();
    total++;
    if (busy3 !== 1'b0 || req3 !== 1'b0 || valid3 !== 1'b0 || wd3 !== held || n_fetch3 !== bf) begin
      $display("FAIL idle_ack: busy=%b req=%b valid=%b data=%h, required 0 0 0 %h", busy3, req3, valid3, wd3, held);
    end else pass_cnt++;
    bw = n_win3; bd = n_done3;
    start3 = 1'b1; tick(); start3 = 1'b0;
    repeat (2) tick();
    start3 = 1'b1; tick(); start3 = 1'b0;
    wait_done3(seen);
    // start coinciding with frame_done must also be ignored
    start3 = 1'b1; tick(); start3 = 1'b0;
    total++;
    if (busy3 !== 1'b0 || req3 !== 1'b0) $display("FAIL start_at_done: busy=%b req=%b, required 0 0", busy3, req3);
    else pass_cnt++;
    repeat (3) tick();
    total++;
    if (!seen || n_win3 - bw !== 4 || n_done3 - bd !== 1 || busy3 !== 1'b0) begin
      $display("FAIL start_busy: windows=%0d dones=%0d busy=%b, required 4 1 0", n_win3 - bw, n_done3 - bd, busy3);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_ack();
    test_stall();
    test_k5();
    test_reset_midframe();
    test_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
